dsp_mac_slice_p: RTL and testbench

- Parametrised successor to the fixed 18x18 DSP48A1-style slice.
- Datapath: pre-adder (D±B), signed multiplier (×A), post-adder/accumulator (Z ± (M + CIN)).
- Adds configurable widths, optional M pipeline stage, a valid-tracking pipeline, synchronous accumulator clear and accumulate mode.
- Sits in the DSP datapath as a drop-in MAC; slices chain through PCOUT→PCIN.

---
 rtl/dsp_mac_slice_p.sv | 156 +++++++++++++++
 tb/tb_dsp_mac_slice_p.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/dsp_mac_slice_p.sv
// Parametrised pre-add / multiply / post-add MAC slice with valid tracking.
// Three register stages (operands, optional M, P); PCOUT chains into the next slice's PCIN.
module dsp_mac_slice_p #(
  parameter int AW   = 18,
  parameter int BW   = 18,
  parameter int PW   = 48,
  parameter int MREG = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [AW-1:0]    a,
  input  logic [BW-1:0]    b,
  input  logic [BW-1:0]    d,
  input  logic [PW-1:0]    c,
  input  logic [PW-1:0]    pcin,
  input  logic             carryin,
  input  logic [5:0]       opmode,
  output logic [AW+BW-1:0] m,
  output logic [PW-1:0]    p,
  output logic [PW-1:0]    pcout,
  output logic [BW-1:0]    bcout,
  output logic             carryout,
  output logic             out_valid
);

  localparam int MW = AW + BW;

  logic [AW-1:0] a1;
  logic [BW-1:0] b1, d1;
  logic [PW-1:0] c1, pcin1;
  logic          cin1, v1;
  logic [5:0]    op1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a1    <= '0;
      b1    <= '0;
      d1    <= '0;
      c1    <= '0;
      pcin1 <= '0;
      cin1  <= 1'b0;
      op1   <= '0;
      v1    <= 1'b0;
    end else if (ce) begin
      a1    <= a;
      b1    <= b;
      d1    <= d;
      c1    <= c;
      pcin1 <= pcin;
      cin1  <= carryin;
      op1   <= opmode;
      v1    <= in_valid;
    end
  end

  logic [BW-1:0] x;
  logic [MW-1:0] m_comb;

  always_comb begin
    x = b1;
    if (op1[0]) x = op1[1] ? (d1 - b1) : (d1 + b1);
  end

  // Both factors widened to MW so the truncated product is the exact signed result.
  assign m_comb = $signed({{AW{x[BW-1]}}, x}) * $signed({{BW{a1[AW-1]}}, a1});

  logic [MW-1:0] m_s;
  logic [PW-1:0] c_s, pcin_s;
  logic          cin_s, v_s;
  logic [5:2]    op_s;

  generate
    if (MREG != 0) begin : g_mreg
      logic [MW-1:0] m2;
      logic [PW-1:0] c2, pcin2;
      logic          cin2, v2;
      logic [5:2]    op2;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          m2    <= '0;
          c2    <= '0;
          pcin2 <= '0;
          cin2  <= 1'b0;
          op2   <= '0;
          v2    <= 1'b0;
        end else if (ce) begin
          m2    <= m_comb;
          c2    <= c1;
          pcin2 <= pcin1;
          cin2  <= cin1;
          op2   <= op1[5:2];
          v2    <= v1;
        end
      end

      assign m_s    = m2;
      assign c_s    = c2;
      assign pcin_s = pcin2;
      assign cin_s  = cin2;
      assign op_s   = op2;
      assign v_s    = v2;
    end else begin : g_mcomb
      assign m_s    = m_comb;
      assign c_s    = c1;
      assign pcin_s = pcin1;
      assign cin_s  = cin1;
      assign op_s   = op1[5:2];
      assign v_s    = v1;
    end
  endgenerate

  logic [PW-1:0] mext, z;
  logic [PW:0]   addend, sum;
  logic          cin_v;

  always_comb begin
    mext   = PW'($signed(m_s));
    cin_v  = cin_s & op_s[5];
    case (op_s[3:2])
      2'b00:   z = '0;
      2'b01:   z = c_s;
      2'b10:   z = pcin_s;
      default: z = p;
    endcase
    // PW+1-bit unsigned arithmetic so bit PW carries the carry or borrow.
    addend = {1'b0, mext} + {{PW{1'b0}}, cin_v};
    sum    = op_s[4] ? ({1'b0, z} - addend) : ({1'b0, z} + addend);
  end

  // P only moves on valid data so bubbles leave an accumulation untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p         <= '0;
      carryout  <= 1'b0;
      out_valid <= 1'b0;
    end else if (ce) begin
      if (clr) begin
        p         <= '0;
        carryout  <= 1'b0;
        out_valid <= 1'b0;
      end else begin
        out_valid <= v_s;
        if (v_s) {carryout, p} <= sum;
      end
    end
  end

  assign m     = m_s;
  assign pcout = p;
  assign bcout = b1;

endmodule

// File: tb/tb_dsp_mac_slice_p.sv
// Directed bench for dsp_mac_slice_p: one MREG=1 and one MREG=0 slice share the stimulus.
module tb_dsp_mac_slice_p;

  logic        clk = 1'b0;
  logic        rst_n, ce, clr, in_valid, carryin;
  logic [17:0] a, b, d;
  logic [47:0] c, pcin;
  logic [5:0]  opmode;

  logic [35:0] m1, m0;
  logic [47:0] p1, p0, pcout1, pcout0;
  logic [17:0] bcout1, bcout0;
  logic        co1, co0, ov1, ov0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dsp_mac_slice_p #(.AW(18), .BW(18), .PW(48), .MREG(1)) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .clr(clr), .in_valid(in_valid),
    .a(a), .b(b), .d(d), .c(c), .pcin(pcin), .carryin(carryin), .opmode(opmode),
    .m(m1), .p(p1), .pcout(pcout1), .bcout(bcout1), .carryout(co1), .out_valid(ov1)
  );

  dsp_mac_slice_p #(.AW(18), .BW(18), .PW(48), .MREG(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .ce(ce), .clr(clr), .in_valid(in_valid),
    .a(a), .b(b), .d(d), .c(c), .pcin(pcin), .carryin(carryin), .opmode(opmode),
    .m(m0), .p(p0), .pcout(pcout0), .bcout(bcout0), .carryout(co0), .out_valid(ov0)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [17:0] av, input logic [17:0] bv, input logic [17:0] dv,
                       input logic [47:0] cv, input logic [5:0] mode, input logic cy);
    a        = av;
    b        = bv;
    d        = dv;
    c        = cv;
    opmode   = mode;
    carryin  = cy;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; ce = 1'b1; clr = 1'b0; in_valid = 1'b0; carryin = 1'b0;
    a = '0; b = '0; d = '0; c = '0; pcin = '0; opmode = '0;
    tick(); tick();
    check("rst_p", 64'(p1), 64'h0);
    check("rst_m", 64'(m1), 64'h0);
    check("rst_ov", 64'(ov1), 64'h0);
    rst_n = 1'b1;
    tick();

    // plain multiply
    issue(18'd3, 18'd5, 18'd0, 48'd0, 6'b000000, 1'b0);
    tick();
    check("mul_m", 64'(m1), 64'd15);
    check("mul_p_mreg0", 64'(p0), 64'd15);
    check("mul_ov_mreg0", 64'(ov0), 64'd1);
    tick();
    check("mul_p", 64'(p1), 64'd15);
    check("mul_ov", 64'(ov1), 64'd1);

    issue(-18'sd2, 18'd3, 18'd0, 48'd0, 6'b000000, 1'b0);
    tick();
    check("neg_m", 64'(m1), 64'hF_FFFF_FFFA);
    tick();
    check("neg_p", 64'(p1), 64'hFFFF_FFFF_FFFA);
    check("neg_co", 64'(co1), 64'h0);

    // pre-adder
    issue(18'd2, 18'd4, 18'd10, 48'd0, 6'b000001, 1'b0);
    tick(); tick();
    check("preadd_p", 64'(p1), 64'd28);
    issue(18'd2, 18'd4, 18'd10, 48'd0, 6'b000011, 1'b0);
    tick(); tick();
    check("presub_p", 64'(p1), 64'd12);
    issue(18'd1, 18'd1, 18'h1FFFF, 48'd0, 6'b000001, 1'b0);
    tick();
    check("wrap_m", 64'(m1), 64'hF_FFFE_0000);
    tick();
    check("wrap_p", 64'(p1), 64'hFFFF_FFFE_0000);

    // accumulate from a cleared P
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr0_p", 64'(p1), 64'h0);
    a = 18'd1; d = '0; c = '0; opmode = 6'b001100; carryin = 1'b0; in_valid = 1'b1;
    b = 18'd1; tick();
    b = 18'd2; tick();
    b = 18'd3; tick();
    check("acc1", 64'(p1), 64'd1);
    b = 18'd4; tick();
    check("acc3", 64'(p1), 64'd3);
    in_valid = 1'b0; tick();
    check("acc6", 64'(p1), 64'd6);
    tick();
    check("acc10", 64'(p1), 64'd10);
    check("acc10_ov", 64'(ov1), 64'd1);
    tick();
    check("bubble_p", 64'(p1), 64'd10);
    check("bubble_ov", 64'(ov1), 64'd0);
    check("acc_mreg0", 64'(p0), 64'd10);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_p", 64'(p1), 64'h0);
    check("clr_ov", 64'(ov1), 64'h0);

    // post-subtract with carry in
    issue(18'd5, 18'd6, 18'd0, 48'd100, 6'b110100, 1'b1);
    tick(); tick();
    check("psub_p", 64'(p1), 64'd69);
    check("psub_co", 64'(co1), 64'd0);
    issue(18'd5, 18'd6, 18'd0, 48'd0, 6'b110100, 1'b1);
    tick(); tick();
    check("borrow_p", 64'(p1), 64'hFFFF_FFFF_FFE1);
    check("borrow_co", 64'(co1), 64'd1);
    check("borrow_pcout", 64'(pcout1), 64'hFFFF_FFFF_FFE1);

    // CE stall with MREG=1; CLR must be ignored while stalled
    issue(18'd7, 18'd9, 18'd0, 48'd0, 6'b000000, 1'b0);
    tick();
    check("stall_m", 64'(m1), 64'd63);
    check("stall_p_mreg0", 64'(p0), 64'd63);
    ce = 1'b0; clr = 1'b1;
    tick(); tick(); tick();
    check("frozen_p", 64'(p1), 64'hFFFF_FFFF_FFE1);
    check("frozen_ov", 64'(ov1), 64'd0);
    check("frozen_m", 64'(m1), 64'd63);
    check("frozen_p_mreg0", 64'(p0), 64'd63);
    clr = 1'b0; ce = 1'b1;
    tick();
    check("late_p", 64'(p1), 64'd63);
    check("late_ov", 64'(ov1), 64'd1);
    check("late_co", 64'(co1), 64'd0);

    // CE stall with MREG=0: two CE edges of latency
    issue(-18'sd3, 18'd4, 18'd0, 48'd0, 6'b000000, 1'b0);
    ce = 1'b0;
    tick(); tick(); tick();
    check("m0_frozen_p", 64'(p0), 64'd63);
    ce = 1'b1;
    tick();
    check("m0_late_p", 64'(p0), 64'hFFFF_FFFF_FFF4);
    check("m0_late_ov", 64'(ov0), 64'd1);
    check("m1_hold_p", 64'(p1), 64'd63);
    check("m1_hold_ov", 64'(ov1), 64'd0);
    tick();
    check("m1_late_p", 64'(p1), 64'hFFFF_FFFF_FFF4);

    // reset while an op is in flight
    issue(18'd2, 18'd2, 18'd0, 48'd0, 6'b000000, 1'b0);
    tick();
    check("pre_rst_bcout", 64'(bcout1), 64'd2);
    check("pre_rst_m", 64'(m1), 64'd4);
    rst_n = 1'b0;
    #1;
    check("arst_p", 64'(p1), 64'h0);
    check("arst_pcout", 64'(pcout1), 64'h0);
    check("arst_m", 64'(m1), 64'h0);
    check("arst_bcout", 64'(bcout1), 64'h0);
    check("arst_co", 64'(co1), 64'h0);
    check("arst_ov", 64'(ov1), 64'h0);
    check("arst_p_mreg0", 64'(p0), 64'h0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_ov", 64'(ov1), 64'h0);
    end
    check("post_rst_p", 64'(p1), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
